// File: rtl/pipeline_controller_pkg.sv
// Shared types for the pipeline sequencer: FSM state encoding and the
// per-state control output bundle.
package pipeline_controller_pkg;

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    BR_EXEC  = 3'd1,
    BR_WB    = 3'd2,
    LD_STALL = 3'd3,
    HALT     = 3'd4
  } pipe_state_t;

  typedef struct packed {
    logic fetch;
    logic decode;
    logic bubble;
    logic completed;
  } ctrl_out_t;

  localparam logic [31:0] STALL_MAX = 32'hFFFF_FFFF;

  function automatic ctrl_out_t decode_state(input pipe_state_t s);
    ctrl_out_t c;
    case (s)
      RUN:      c = ctrl_out_t'(4'b1100);
      BR_EXEC:  c = ctrl_out_t'(4'b1010);
      BR_WB:    c = ctrl_out_t'(4'b1010);
      LD_STALL: c = ctrl_out_t'(4'b0010);
      HALT:     c = ctrl_out_t'(4'b0011);
      default:  c = ctrl_out_t'(4'b0010);
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipeline_controller_hazard_detect.sv
// Combinational load-use comparator between the execute-stage load
// destination and the decode-stage source registers.
module hazard_detect (
  input  logic       LOAD_IN_EXEC,
  input  logic [4:0] EXEC_RD,
  input  logic [4:0] DEC_RS1,
  input  logic [4:0] DEC_RS2,
  input  logic       DEC_USES_RS1,
  input  logic       DEC_USES_RS2,
  output logic       HAZARD
);

  // x0 never carries a dependency, so a load to it cannot stall
  assign HAZARD = LOAD_IN_EXEC && (EXEC_RD != 5'd0) &&
                  ((DEC_USES_RS1 && (DEC_RS1 == EXEC_RD)) ||
                   (DEC_USES_RS2 && (DEC_RS2 == EXEC_RD)));

endmodule

// File: rtl/pipeline_controller.sv
// Fetch/decode/execute/write sequencer: owns the fetch PC, inserts load-use
// bubbles, performs the two-cycle branch redirect and latches completion.
module pipeline_controller
  import pipeline_controller_pkg::*;
#(
  parameter int unsigned           PC_WIDTH = 32'd32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = {PC_WIDTH{1'b0}},
  parameter logic [PC_WIDTH-1:0]   FINAL_PC = PC_WIDTH'(32'd35)
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                BRANCH_IN_DECODE,
  input  logic [4:0]          DEC_RS1,
  input  logic [4:0]          DEC_RS2,
  input  logic                DEC_USES_RS1,
  input  logic                DEC_USES_RS2,
  input  logic                LOAD_IN_EXEC,
  input  logic [4:0]          EXEC_RD,
  input  logic [PC_WIDTH-1:0] JUMP_DEST,
  input  logic                WB_VALID,
  input  logic [PC_WIDTH-1:0] WB_PC,
  output logic [PC_WIDTH-1:0] PC,
  output logic                FETCH_ENABLED,
  output logic                DECODER_ENABLED,
  output logic                BUBBLE,
  output logic                COMPLETED,
  output logic [31:0]         STALL_COUNT
);

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  pipe_state_t         state_r, state_next_s;
  logic [PC_WIDTH-1:0] pc_r, pc_next_s;
  logic [31:0]         stall_count_r;
  ctrl_out_t           ctrl_r;
  logic                hazard_s, halt_s, stalling_s;

  hazard_detect u_hazard (
    .LOAD_IN_EXEC (LOAD_IN_EXEC),
    .EXEC_RD      (EXEC_RD),
    .DEC_RS1      (DEC_RS1),
    .DEC_RS2      (DEC_RS2),
    .DEC_USES_RS1 (DEC_USES_RS1),
    .DEC_USES_RS2 (DEC_USES_RS2),
    .HAZARD       (hazard_s)
  );

  assign halt_s     = WB_VALID && (WB_PC == FINAL_PC);
  assign stalling_s = (state_r == BR_EXEC) || (state_r == BR_WB) || (state_r == LD_STALL);

  // Next-state and next-PC selection; halt outranks everything outside HALT
  always_comb begin
    state_next_s = state_r;
    pc_next_s    = pc_r;
    case (state_r)
      RUN: begin
        if (halt_s) begin
          state_next_s = HALT;
        end else if (hazard_s) begin
          state_next_s = LD_STALL;
        end else if (BRANCH_IN_DECODE) begin
          state_next_s = BR_EXEC;
        end else begin
          pc_next_s = pc_r + PC_ONE;
        end
      end
      BR_EXEC: begin
        if (halt_s) begin
          state_next_s = HALT;
        end else begin
          // fetch register trails PC by one, so aim one short of the target
          state_next_s = BR_WB;
          pc_next_s    = JUMP_DEST - PC_ONE;
        end
      end
      BR_WB: begin
        if (halt_s) begin
          state_next_s = HALT;
        end else begin
          state_next_s = RUN;
          pc_next_s    = pc_r + PC_ONE;
        end
      end
      LD_STALL: begin
        if (halt_s) begin
          state_next_s = HALT;
        end else begin
          state_next_s = RUN;
        end
      end
      HALT:    state_next_s = HALT;
      default: state_next_s = RUN;
    endcase
  end

  // FSM state, PC and registered Moore control outputs
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_r <= RUN;
      pc_r    <= RESET_PC;
      ctrl_r  <= decode_state(RUN);
    end else begin
      state_r <= state_next_s;
      pc_r    <= pc_next_s;
      ctrl_r  <= decode_state(state_next_s);
    end
  end

  // Saturating count of cycles spent in a stall or redirect state
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      stall_count_r <= 32'd0;
    end else if (stalling_s && (stall_count_r != STALL_MAX)) begin
      stall_count_r <= stall_count_r + 32'd1;
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign PC              = pc_r;
  assign FETCH_ENABLED   = ctrl_r.fetch;
  assign DECODER_ENABLED = ctrl_r.decode;
  assign BUBBLE          = ctrl_r.bubble;
  assign COMPLETED       = ctrl_r.completed;
  assign STALL_COUNT     = stall_count_r;

endmodule

// File: tb/tb_pipeline_controller.sv
// Scoreboard bench for pipeline_controller: a reference model pushes the
// expected output vector per cycle, popped and compared after each edge.
module tb_pipeline_controller;

  localparam int S_RUN = 0, S_BRX = 1, S_BRW = 2, S_LD = 3, S_HALT = 4;

  logic        CLK = 1'b0, RSTN = 1'b0;
  logic        BRANCH_IN_DECODE = 1'b0;
  logic [4:0]  DEC_RS1 = 5'd0, DEC_RS2 = 5'd0, EXEC_RD = 5'd0;
  logic        DEC_USES_RS1 = 1'b0, DEC_USES_RS2 = 1'b0, LOAD_IN_EXEC = 1'b0;
  logic [31:0] JUMP_DEST = 32'd0, WB_PC = 32'd0;
  logic        WB_VALID = 1'b0;
  logic [31:0] PC, STALL_COUNT;
  logic        FETCH_ENABLED, DECODER_ENABLED, BUBBLE, COMPLETED;

  typedef logic [67:0] obs_t;
  obs_t obs;
  obs_t sb[$];
  int n_checks = 0, n_fail = 0;
  int m_state;
  logic [31:0] m_pc, m_cnt;

  pipeline_controller #(.PC_WIDTH(32), .RESET_PC(32'd0), .FINAL_PC(32'd35)) dut (
    .CLK(CLK), .RSTN(RSTN), .BRANCH_IN_DECODE(BRANCH_IN_DECODE),
    .DEC_RS1(DEC_RS1), .DEC_RS2(DEC_RS2), .DEC_USES_RS1(DEC_USES_RS1),
    .DEC_USES_RS2(DEC_USES_RS2), .LOAD_IN_EXEC(LOAD_IN_EXEC), .EXEC_RD(EXEC_RD),
    .JUMP_DEST(JUMP_DEST), .WB_VALID(WB_VALID), .WB_PC(WB_PC), .PC(PC),
    .FETCH_ENABLED(FETCH_ENABLED), .DECODER_ENABLED(DECODER_ENABLED),
    .BUBBLE(BUBBLE), .COMPLETED(COMPLETED), .STALL_COUNT(STALL_COUNT)
  );

  always #5 CLK = ~CLK;

  assign obs = {PC, FETCH_ENABLED, DECODER_ENABLED, BUBBLE, COMPLETED, STALL_COUNT};

  function automatic logic [3:0] m_dec(input int s);
    case (s)
      S_RUN:   return 4'b1100;
      S_BRX:   return 4'b1010;
      S_BRW:   return 4'b1010;
      S_LD:    return 4'b0010;
      default: return 4'b0011;
    endcase
  endfunction

  task automatic model_push();
    logic halt, hz;
    int ns;
    logic [31:0] npc;
    halt = WB_VALID && (WB_PC == 32'd35);
    hz = LOAD_IN_EXEC && (EXEC_RD != 5'd0) &&
         ((DEC_USES_RS1 && DEC_RS1 == EXEC_RD) || (DEC_USES_RS2 && DEC_RS2 == EXEC_RD));
    ns = m_state;
    npc = m_pc;
    if (m_state != S_HALT && halt) ns = S_HALT;
    else if (m_state == S_RUN) begin
      if (hz) ns = S_LD;
      else if (BRANCH_IN_DECODE) ns = S_BRX;
      else npc = m_pc + 32'd1;
    end else if (m_state == S_BRX) begin
      ns = S_BRW;
      npc = JUMP_DEST - 32'd1;
    end else if (m_state == S_BRW) begin
      ns = S_RUN;
      npc = m_pc + 32'd1;
    end else if (m_state == S_LD) ns = S_RUN;
    if ((m_state == S_BRX || m_state == S_BRW || m_state == S_LD) && m_cnt != 32'hFFFF_FFFF)
      m_cnt = m_cnt + 32'd1;
    m_state = ns;
    m_pc = npc;
    sb.push_back({m_pc, m_dec(m_state), m_cnt});
  endtask

  task automatic tick(output obs_t e);
    model_push();
    @(posedge CLK);
    #1;
    e = sb.pop_front();
  endtask

  task automatic clear_inputs();
    BRANCH_IN_DECODE = 1'b0; LOAD_IN_EXEC = 1'b0; EXEC_RD = 5'd0;
    DEC_RS1 = 5'd0; DEC_RS2 = 5'd0; DEC_USES_RS1 = 1'b0; DEC_USES_RS2 = 1'b0;
    WB_VALID = 1'b0; WB_PC = 32'd0; JUMP_DEST = 32'd0;
  endtask

  task automatic pulse_reset(input string name);
    RSTN = 1'b0;
    #1;
    sb.delete();
    m_state = S_RUN; m_pc = 32'd0; m_cnt = 32'd0;
    n_checks++;
    if (obs !== {32'd0, 4'b1100, 32'd0}) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, obs, {32'd0, 4'b1100, 32'd0});
    end
    @(negedge CLK);
    RSTN = 1'b1;
  endtask

  task automatic test_reset();
    obs_t e;
    clear_inputs();
    repeat (2) @(posedge CLK);
    #1;
    pulse_reset("reset_state");
    for (int i = 1; i <= 5; i++) begin
      tick(e);
      n_checks++;
      if (obs !== e || PC !== 32'(i)) begin
        n_fail++;
        $display("FAIL clean_run: got %h expected %h", obs, e);
      end
    end
  endtask

  task automatic test_branch();
    obs_t e;
    while (PC != 32'd9) tick(e);
    BRANCH_IN_DECODE = 1'b1;
    tick(e);
    n_checks++;
    if (obs !== e || DECODER_ENABLED !== 1'b0 || PC !== 32'd9) begin
      n_fail++; $display("FAIL branch_exec: got %h expected %h", obs, e);
    end
    JUMP_DEST = 32'd12;
    tick(e);
    BRANCH_IN_DECODE = 1'b0;
    n_checks++;
    if (obs !== e || PC !== 32'd11 || DECODER_ENABLED !== 1'b0) begin
      n_fail++; $display("FAIL branch_wb: got %h expected %h", obs, e);
    end
    tick(e);
    n_checks++;
    if (obs !== e || PC !== 32'd12 || STALL_COUNT !== 32'd2 || DECODER_ENABLED !== 1'b1) begin
      n_fail++; $display("FAIL branch_done: got %h expected %h", obs, e);
    end
    BRANCH_IN_DECODE = 1'b1;
    JUMP_DEST = 32'd0;
    tick(e);
    BRANCH_IN_DECODE = 1'b0;
    tick(e);
    n_checks++;
    if (obs !== e || PC !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL branch_zero_wrap: got %h expected %h", obs, e);
    end
    tick(e);
    n_checks++;
    if (obs !== e || PC !== 32'd0 || STALL_COUNT !== 32'd4) begin
      n_fail++; $display("FAIL branch_zero_done: got %h expected %h", obs, e);
    end
  endtask

  task automatic test_load_use();
    obs_t e;
    logic [31:0] pc0;
    pc0 = PC;
    LOAD_IN_EXEC = 1'b1; EXEC_RD = 5'd15; DEC_RS1 = 5'd15; DEC_USES_RS1 = 1'b1;
    tick(e);
    n_checks++;
    if (obs !== e || PC !== pc0 || BUBBLE !== 1'b1 || FETCH_ENABLED !== 1'b0) begin
      n_fail++; $display("FAIL load_stall: got %h expected %h", obs, e);
    end
    LOAD_IN_EXEC = 1'b0;
    tick(e);
    tick(e);
    n_checks++;
    if (obs !== e || PC !== pc0 + 32'd1) begin
      n_fail++; $display("FAIL load_resume: got %h expected %h", obs, e);
    end
    LOAD_IN_EXEC = 1'b1; EXEC_RD = 5'd0; DEC_RS1 = 5'd0;
    tick(e);
    n_checks++;
    if (obs !== e || BUBBLE !== 1'b0 || PC !== pc0 + 32'd2) begin
      n_fail++; $display("FAIL load_x0: got %h expected %h", obs, e);
    end
    EXEC_RD = 5'd7; DEC_RS1 = 5'd3; DEC_USES_RS1 = 1'b1; DEC_RS2 = 5'd7; DEC_USES_RS2 = 1'b0;
    tick(e);
    n_checks++;
    if (obs !== e || BUBBLE !== 1'b0) begin
      n_fail++; $display("FAIL load_rs2_unused: got %h expected %h", obs, e);
    end
    DEC_USES_RS2 = 1'b1;
    tick(e);
    n_checks++;
    if (obs !== e || BUBBLE !== 1'b1) begin
      n_fail++; $display("FAIL load_rs2: got %h expected %h", obs, e);
    end
    clear_inputs();
    tick(e);
  endtask

  task automatic test_load_branch();
    obs_t e;
    logic [31:0] cnt0;
    cnt0 = STALL_COUNT;
    LOAD_IN_EXEC = 1'b1; EXEC_RD = 5'd4; DEC_RS2 = 5'd4; DEC_USES_RS2 = 1'b1;
    BRANCH_IN_DECODE = 1'b1; JUMP_DEST = 32'd20;
    tick(e);
    n_checks++;
    if (obs !== e || BUBBLE !== 1'b1 || FETCH_ENABLED !== 1'b0) begin
      n_fail++; $display("FAIL load_branch_stall: got %h expected %h", obs, e);
    end
    LOAD_IN_EXEC = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(e);
      if (i == 1) BRANCH_IN_DECODE = 1'b0;
      n_checks++;
      if (obs !== e) begin
        n_fail++; $display("FAIL load_branch_seq: got %h expected %h", obs, e);
      end
    end
    n_checks++;
    if (PC !== 32'd20 || STALL_COUNT !== cnt0 + 32'd3) begin
      n_fail++; $display("FAIL load_branch_penalty: got pc %h cnt %h expected pc 20 cnt %h", PC, STALL_COUNT, cnt0 + 32'd3);
    end
    clear_inputs();
  endtask

  task automatic test_halt();
    obs_t e;
    logic [31:0] pc0, cnt0;
    WB_VALID = 1'b1; WB_PC = 32'd34;
    tick(e);
    n_checks++;
    if (obs !== e || COMPLETED !== 1'b0) begin
      n_fail++; $display("FAIL halt_near_miss: got %h expected %h", obs, e);
    end
    WB_VALID = 1'b0;
    BRANCH_IN_DECODE = 1'b1;
    tick(e);
    pc0 = PC; cnt0 = STALL_COUNT;
    WB_VALID = 1'b1; WB_PC = 32'd35; JUMP_DEST = 32'd30;
    tick(e);
    n_checks++;
    if (obs !== e || COMPLETED !== 1'b1 || PC !== pc0 || STALL_COUNT !== cnt0 + 32'd1) begin
      n_fail++; $display("FAIL halt_enter: got %h expected %h", obs, e);
    end
    WB_VALID = 1'b0; LOAD_IN_EXEC = 1'b1; EXEC_RD = 5'd2; DEC_RS1 = 5'd2; DEC_USES_RS1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(e);
      n_checks++;
      if (obs !== e || COMPLETED !== 1'b1 || PC !== pc0 || STALL_COUNT !== cnt0 + 32'd1) begin
        n_fail++; $display("FAIL halt_sticky: got %h expected %h", obs, e);
      end
    end
    clear_inputs();
    pulse_reset("halt_reset");
    tick(e);
    n_checks++;
    if (obs !== e || PC !== 32'd1 || COMPLETED !== 1'b0) begin
      n_fail++; $display("FAIL halt_restart: got %h expected %h", obs, e);
    end
  endtask

  task automatic test_reset_abort();
    obs_t e;
    BRANCH_IN_DECODE = 1'b1; JUMP_DEST = 32'd25;
    tick(e);
    BRANCH_IN_DECODE = 1'b0;
    pulse_reset("abort_reset");
    tick(e);
    tick(e);
    n_checks++;
    if (obs !== e || PC !== 32'd2 || DECODER_ENABLED !== 1'b1 || STALL_COUNT !== 32'd0) begin
      n_fail++; $display("FAIL abort_no_target: got %h expected %h", obs, e);
    end
  endtask

  task automatic test_saturation();
    obs_t e;
    force dut.stall_count_r = 32'hFFFF_FFFE;
    #1;
    release dut.stall_count_r;
    m_cnt = 32'hFFFF_FFFE;
    BRANCH_IN_DECODE = 1'b1; JUMP_DEST = 32'd8;
    tick(e);
    BRANCH_IN_DECODE = 1'b0;
    tick(e);
    n_checks++;
    if (obs !== e || STALL_COUNT !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL sat_reach: got %h expected %h", obs, e);
    end
    tick(e);
    LOAD_IN_EXEC = 1'b1; EXEC_RD = 5'd9; DEC_RS1 = 5'd9; DEC_USES_RS1 = 1'b1;
    tick(e);
    clear_inputs();
    tick(e);
    tick(e);
    n_checks++;
    if (obs !== e || STALL_COUNT !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL sat_hold: got %h expected %h", obs, e);
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_load_use();
    test_load_branch();
    test_halt();
    test_reset_abort();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
